// File: rtl/cache_port_arbiter_pkg.sv
// cachepkg: shared types for the cache port arbiter slice.
// Holds client op encoding, arbitration mode, FSM states, port wrap helper.
package cachepkg;

  typedef enum logic [1:0] {
    NOP,
    READ,
    WRITE,
    FLUSH
  } inst_t;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arbmode_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COMPLETE
  } arb_state_t;

  function automatic int next_port(int cur, int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: client-side and cache-side request/valid buses.
// slave = arbiter view; master = environment (clients + cache) view.
interface cache_port_arbiter_if #(
  parameter int DATAWIDTH    = 8,
  parameter int ADDRESSWIDTH = 32,
  parameter int NUMPORTS     = 4
);
  import cachepkg::*;

  inst_t                    cl_operation [NUMPORTS];
  logic [ADDRESSWIDTH-1:0]  cl_addr_in   [NUMPORTS];
  logic [DATAWIDTH-1:0]     cl_d_in      [NUMPORTS];
  logic [NUMPORTS-1:0]      cl_request;
  logic [NUMPORTS-1:0]      cl_valid;
  logic [NUMPORTS-1:0]      cl_evict;
  logic [ADDRESSWIDTH-1:0]  cl_addr_out;
  logic [DATAWIDTH-1:0]     cl_d_out;

  inst_t                    c_operation;
  logic [ADDRESSWIDTH-1:0]  c_addr_in;
  logic [DATAWIDTH-1:0]     c_d_in;
  logic                     c_request;
  logic                     c_valid;
  logic                     c_evict;
  logic [ADDRESSWIDTH-1:0]  c_addr_out;
  logic [DATAWIDTH-1:0]     c_d_out;

  modport slave (
    input  cl_operation, cl_addr_in, cl_d_in, cl_request,
    input  c_valid, c_evict, c_addr_out, c_d_out,
    output cl_valid, cl_evict, cl_addr_out, cl_d_out,
    output c_operation, c_addr_in, c_d_in, c_request
  );

  modport master (
    output cl_operation, cl_addr_in, cl_d_in, cl_request,
    output c_valid, c_evict, c_addr_out, c_d_out,
    input  cl_valid, cl_evict, cl_addr_out, cl_d_out,
    input  c_operation, c_addr_in, c_d_in, c_request
  );

endinterface

// File: rtl/cache_port_arbiter_rr_select.sv
// rr_select: combinational winner pick from a request vector.
// In: req, last_grant, mode. Out: winner index, any_req.
module rr_select
  import cachepkg::*;
#(
  parameter  int NUMPORTS = 4,
  localparam int GW = $clog2(NUMPORTS)
) (
  input  logic [NUMPORTS-1:0] req,
  input  logic [GW-1:0]       last_grant,
  input  arbmode_t            mode,
  output logic [GW-1:0]       winner,
  output logic                any_req
);

  int   idx;
  logic found;

  // Scan all ports once starting from the mode-dependent origin;
  // the first requester hit wins.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    idx     = (mode == ARB_RR) ?
              next_port(int'(last_grant), NUMPORTS) : 0;
    for (int i = 0; i < NUMPORTS; i++) begin
      if (!found && req[idx[GW-1:0]]) begin
        winner = idx[GW-1:0];
        found  = 1'b1;
      end
      idx = next_port(idx, NUMPORTS);
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: NUMPORTS clients onto one cache port, one txn at a time.
// Ports: clock, reset (async low), bus (slave), grant, busy, evict_count.
module cache_port_arbiter
  import cachepkg::*;
#(
  parameter  int DATAWIDTH    = 8,
  parameter  int ADDRESSWIDTH = 32,
  parameter  int NUMPORTS     = 4,
  parameter  int ROUNDROBIN   = 1,
  parameter  int CNTWIDTH     = 16,
  localparam int GW = $clog2(NUMPORTS)
) (
  input  logic                clock,
  input  logic                reset,
  cache_port_arbiter_if.slave bus,
  output logic [GW-1:0]       grant,
  output logic                busy,
  output logic [CNTWIDTH-1:0] evict_count [NUMPORTS]
);

  localparam arbmode_t MODE =
    (ROUNDROBIN != 0) ? ARB_RR : ARB_FIXED;

  arb_state_t state, state_n;

  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           winner;
  logic                    any_req;
  logic                    do_grant;
  logic                    do_resp;
  logic                    do_rel;
  logic [NUMPORTS-1:0]     gmask;

  inst_t                   req_op;
  logic [ADDRESSWIDTH-1:0] req_addr;
  logic [DATAWIDTH-1:0]    req_data;
  logic                    req_q;
  logic [NUMPORTS-1:0]     valid_q;
  logic [NUMPORTS-1:0]     evict_q;
  logic [ADDRESSWIDTH-1:0] rsp_addr;
  logic [DATAWIDTH-1:0]    rsp_data;

  rr_select #(
    .NUMPORTS (NUMPORTS)
  ) u_sel (
    .req        (bus.cl_request),
    .last_grant (last_grant),
    .mode       (MODE),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign gmask = NUMPORTS'(1) << grant;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    do_grant = 1'b0;
    do_resp  = 1'b0;
    do_rel   = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          do_grant = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.c_valid) begin
          do_resp = 1'b1;
          state_n = COMPLETE;
        end
      end
      COMPLETE: begin
        // Only the granted port's request matters; a port
        // that dropped early just releases once c_valid is low.
        if (!bus.cl_request[grant] && !bus.c_valid) begin
          do_rel  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // Last grant parked on the top port so port 0 goes first.
      last_grant <= GW'(NUMPORTS - 1);
      grant      <= '0;
      busy       <= 1'b0;
      req_op     <= NOP;
      req_addr   <= '0;
      req_data   <= '0;
      req_q      <= 1'b0;
      valid_q    <= '0;
      evict_q    <= '0;
      rsp_addr   <= '0;
      rsp_data   <= '0;
      for (int i = 0; i < NUMPORTS; i++) begin
        evict_count[i] <= '0;
      end
    end else begin
      busy <= (state_n != IDLE);
      if (do_grant) begin
        grant      <= winner;
        last_grant <= winner;
        req_op     <= bus.cl_operation[winner];
        req_addr   <= bus.cl_addr_in[winner];
        req_data   <= bus.cl_d_in[winner];
        req_q      <= 1'b1;
      end
      if (do_resp) begin
        req_q    <= 1'b0;
        valid_q  <= gmask;
        evict_q  <= bus.c_evict ? gmask : '0;
        rsp_addr <= bus.c_addr_out;
        rsp_data <= bus.c_d_out;
        if (bus.c_evict && evict_count[grant] != '1) begin
          evict_count[grant] <= evict_count[grant] + 1'b1;
        end
      end
      if (do_rel) begin
        valid_q <= '0;
        evict_q <= '0;
      end
    end
  end

  assign bus.c_operation = req_op;
  assign bus.c_addr_in   = req_addr;
  assign bus.c_d_in      = req_data;
  assign bus.c_request   = req_q;
  assign bus.cl_valid    = valid_q;
  assign bus.cl_evict    = evict_q;
  assign bus.cl_addr_out = rsp_addr;
  assign bus.cl_d_out    = rsp_data;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed bench, round-robin and fixed-priority DUTs.
// Both DUTs see identical client stimulus; each has its own cache/client model.
module tb_cache_port_arbiter;
  import cachepkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  inst_t          op_tb   [N];
  logic [AW-1:0]  addr_tb [N];
  logic [DW-1:0]  din_tb  [N];
  logic [N-1:0]   want       = '0;
  logic [N-1:0]   drop_ok    = '1;
  logic           evict_flag = 1'b0;
  int             cache_wait = 0;

  cache_port_arbiter_if #(
    .DATAWIDTH(DW), .ADDRESSWIDTH(AW), .NUMPORTS(N)
  ) bus [2] ();

  logic [1:0]  grant0, grant1;
  logic        busy0, busy1;
  logic [15:0] ec0 [N];
  logic [1:0]  ec1 [N];

  cache_port_arbiter #(
    .DATAWIDTH(DW), .ADDRESSWIDTH(AW), .NUMPORTS(N),
    .ROUNDROBIN(1), .CNTWIDTH(16)
  ) u_rr (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus[0]),
    .grant       (grant0),
    .busy        (busy0),
    .evict_count (ec0)
  );

  cache_port_arbiter #(
    .DATAWIDTH(DW), .ADDRESSWIDTH(AW), .NUMPORTS(N),
    .ROUNDROBIN(0), .CNTWIDTH(2)
  ) u_fp (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus[1]),
    .grant       (grant1),
    .busy        (busy1),
    .evict_count (ec1)
  );

  for (genvar g = 0; g < 2; g++) begin : g_env
    int cnt;

    assign bus[g].cl_operation = op_tb;
    assign bus[g].cl_addr_in   = addr_tb;
    assign bus[g].cl_d_in      = din_tb;

    // cache: answers after cache_wait cycles, data = addr[7:0] + A5
    initial begin
      cnt = 0;
      bus[g].c_valid    = 1'b0;
      bus[g].c_evict    = 1'b0;
      bus[g].c_addr_out = '0;
      bus[g].c_d_out    = '0;
      forever begin
        @(posedge clock);
        #1;
        if (!bus[g].c_request) begin
          bus[g].c_valid = 1'b0;
          cnt = 0;
        end else if (!bus[g].c_valid) begin
          if (cnt >= cache_wait) begin
            bus[g].c_valid    = 1'b1;
            bus[g].c_evict    = evict_flag;
            bus[g].c_addr_out = bus[g].c_addr_in;
            bus[g].c_d_out    = bus[g].c_addr_in[7:0] + 8'hA5;
          end else begin
            cnt++;
          end
        end
      end
    end

    // clients: request while wanted, drop after valid if allowed
    initial begin
      bus[g].cl_request = '0;
      forever begin
        @(posedge clock);
        #2;
        bus[g].cl_request = want & ~(bus[g].cl_valid & drop_ok);
      end
    end

    always @(negedge clock) begin
      checks++;
      assert ($onehot0(bus[g].cl_valid)) else begin
        errors++;
        $error("FAIL onehot%0d obs=%b exp=onehot0",
               g, bus[g].cl_valid);
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  logic [4:0] ev;
  int exp0 [5];
  int exp1 [5];

  initial begin
    op_tb   = '{WRITE, READ, READ, WRITE};
    addr_tb = '{32'h40, 32'h80, 32'h100, 32'h200};
    din_tb  = '{8'h10, 8'h11, 8'h12, 8'h13};
    ev      = 5'b11101;
    exp0    = '{1, 1, 2, 3, 4};
    exp1    = '{1, 1, 2, 3, 3};

    // reset state
    @(negedge clock);
    chk("rst_busy0", busy0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_grant0", grant0, 0);
    chk("rst_creq0", bus[0].c_request, 0);
    chk("rst_valid1", bus[1].cl_valid, 0);
    chk("rst_op0", bus[0].c_operation, NOP);
    chk("rst_cnt0", ec0[1], 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // all ports requesting continuously
    want = 4'hF;
    @(posedge clock);
    for (int k = 0; k < 6; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk("rr_valid", bus[0].cl_valid, 32'd1 << (k % 4));
      chk("rr_grant", grant0, k % 4);
      chk("fp_valid", bus[1].cl_valid, 1);
      chk("fp_grant", grant1, 0);
      @(posedge clock);
      @(posedge clock);
    end
    #1 want = '0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("drain_busy0", busy0, 0);
    chk("drain_busy1", busy1, 0);

    // single request, port 2, zero-wait cache
    @(posedge clock); #1;
    want = 4'b0100;
    @(posedge clock);
    @(negedge clock);
    chk("s_creq0", bus[0].c_request, 1);
    chk("s_creq1", bus[1].c_request, 1);
    chk("s_grant0", grant0, 2);
    chk("s_grant1", grant1, 2);
    chk("s_caddr", bus[0].c_addr_in, 32'h100);
    chk("s_cop", bus[0].c_operation, READ);
    chk("s_cdin", bus[0].c_d_in, 8'h12);
    chk("s_novalid", bus[0].cl_valid, 0);
    @(posedge clock); #1;
    want = '0;
    @(negedge clock);
    chk("s_valid0", bus[0].cl_valid, 4'b0100);
    chk("s_valid1", bus[1].cl_valid, 4'b0100);
    chk("s_dout", bus[0].cl_d_out, 8'hA5);
    chk("s_aout", bus[1].cl_addr_out, 32'h100);
    chk("s_creq_lo", bus[0].c_request, 0);
    chk("s_busy", busy0, 1);
    @(posedge clock);
    @(negedge clock);
    chk("s_rel_valid", bus[0].cl_valid, 0);
    chk("s_rel_busy", busy1, 0);

    // evictions on port 1; FP DUT has a 2-bit counter
    @(posedge clock); #1;
    evict_flag = ev[0];
    want = 4'b0010;
    @(posedge clock);
    for (int k = 0; k < 5; k++) begin
      @(posedge clock);
      @(negedge clock);
      chk("ev_valid0", bus[0].cl_valid, 4'b0010);
      chk("ev_flag0", bus[0].cl_evict, ev[k] ? 4'b0010 : 4'b0);
      chk("ev_flag1", bus[1].cl_evict, ev[k] ? 4'b0010 : 4'b0);
      chk("ev_cnt0", ec0[1], exp0[k]);
      chk("ev_cnt1", ec1[1], exp1[k]);
      if (k < 4) evict_flag = ev[k+1];
      else       evict_flag = 1'b0;
      @(posedge clock);
      @(posedge clock);
    end
    #1 want = '0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("ev_final0", ec0[1], 4);
    chk("ev_sat1", ec1[1], 3);
    chk("ev_other0", ec0[0], 0);
    chk("ev_other1", ec1[2], 0);

    // client holds request after valid; port 3 waits
    @(posedge clock); #1;
    want    = 4'b1100;
    drop_ok = '0;
    @(posedge clock);
    @(posedge clock);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("hold_valid0", bus[0].cl_valid, 4'b0100);
      chk("hold_valid1", bus[1].cl_valid, 4'b0100);
      chk("hold_busy", busy0, 1);
      @(posedge clock);
    end
    #1;
    drop_ok = '1;
    want    = 4'b1000;
    @(posedge clock);
    @(negedge clock);
    chk("hold_rel0", bus[0].cl_valid, 0);
    chk("hold_rel1", bus[1].cl_valid, 0);
    @(posedge clock);
    @(negedge clock);
    chk("next_grant0", grant0, 3);
    chk("next_grant1", grant1, 3);
    chk("next_creq", bus[1].c_request, 1);
    chk("next_addr", bus[0].c_addr_in, 32'h200);
    @(posedge clock); #1;
    want = '0;
    repeat (5) @(posedge clock);

    // client drops before valid; slow cache
    @(posedge clock); #1;
    cache_wait = 2;
    want = 4'b0001;
    @(posedge clock); #1;
    want = '0;
    @(negedge clock);
    chk("pv_creq_a", bus[0].c_request, 1);
    @(posedge clock);
    @(negedge clock);
    chk("pv_creq_b", bus[1].c_request, 1);
    chk("pv_busy", busy0, 1);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("pv_valid0", bus[0].cl_valid, 4'b0001);
    chk("pv_valid1", bus[1].cl_valid, 4'b0001);
    chk("pv_dout", bus[0].cl_d_out, 8'hE5);
    @(posedge clock);
    @(negedge clock);
    chk("pv_rel", bus[0].cl_valid, 0);
    chk("pv_idle", busy1, 0);

    // reset during ISSUE
    @(posedge clock); #1;
    cache_wait = 3;
    want = 4'hF;
    @(posedge clock);
    @(negedge clock);
    chk("ri_creq0", bus[0].c_request, 1);
    chk("ri_busy1", busy1, 1);
    #2 reset = 1'b0;
    #1;
    chk("ri_creq_lo0", bus[0].c_request, 0);
    chk("ri_creq_lo1", bus[1].c_request, 0);
    chk("ri_busy_lo", busy0, 0);
    chk("ri_valid_lo", bus[0].cl_valid, 0);
    chk("ri_cnt_lo", ec0[1], 0);
    @(posedge clock); #1;
    reset = 1'b1;
    cache_wait = 0;
    @(posedge clock);
    @(negedge clock);
    chk("ri_grant0", grant0, 0);
    chk("ri_grant1", grant1, 0);
    chk("ri_creq_hi", bus[0].c_request, 1);
    @(posedge clock); #1;
    want = '0;
    repeat (6) @(posedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
